axis_frame_source: RTL

//  Frames the two-channel microphone PCM stream into FRAME_LEN-sample blocks for the correlation/DOA path.

---
 rtl/axis_frame_source.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/axis_frame_source.sv
// Two-channel PCM framer: ping-pong capture into FRAME_LEN-sample banks, each full bank
// replayed as two lockstep AXI-Stream masters of complex words {im=0, re=sample}.
module axis_frame_source #(
    parameter int DATA_W    = 32,
    parameter int FRAME_LEN = 4096,
    parameter int ADDR_W    = 12,
    parameter int CNT_W     = 16
) (
    input  logic                axis_aclk,
    input  logic                axis_aresetn,
    input  logic                enable,
    input  logic                pcm_valid,
    input  logic [DATA_W-1:0]   pcm_data0,
    input  logic [DATA_W-1:0]   pcm_data1,
    output logic [2*DATA_W-1:0] m00_axis_tdata,
    output logic                m00_axis_tvalid,
    input  logic                m00_axis_tready,
    output logic                m00_axis_tlast,
    output logic [2*DATA_W-1:0] m01_axis_tdata,
    output logic                m01_axis_tvalid,
    input  logic                m01_axis_tready,
    output logic                m01_axis_tlast,
    output logic                overrun,
    input  logic                overrun_clr,
    output logic [CNT_W-1:0]    frame_cnt
);
    localparam int PAIR_W = 2 * DATA_W;

    typedef enum logic [1:0] {IDLE, FETCH, STREAM} state_t;

    logic [PAIR_W-1:0] mem [2*FRAME_LEN];
    logic [PAIR_W-1:0] ram_q, out_pair;
    logic [1:0]        full;
    logic              wr_bank, rd_bank;
    logic [ADDR_W-1:0] wr_cnt, rd_ptr, rd_addr, beat_idx;
    logic              wr_en, wr_done, rd_en, xfer, release_bank;
    logic              out_valid, out_last;
    state_t            state, state_nxt;

    assign wr_en   = enable && pcm_valid && !full[wr_bank];
    assign wr_done = wr_en && (wr_cnt == ADDR_W'(FRAME_LEN - 1));
    assign xfer    = out_valid && m00_axis_tready && m01_axis_tready;

    // NOTE: buffer RAM has no reset so it maps onto block RAM; only control state is reset.
    always_ff @(posedge axis_aclk) begin
        if (wr_en)
            mem[{wr_bank, wr_cnt}] <= {pcm_data1, pcm_data0};
        if (rd_en)
            ram_q <= mem[{rd_bank, rd_addr}];
    end

    // Capture side; a disabled input drops any partial frame.
    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            full    <= '0;
            wr_bank <= 1'b0;
            wr_cnt  <= '0;
            overrun <= 1'b0;
        end else begin
            if (release_bank)
                full[rd_bank] <= 1'b0;
            if (wr_done)
                full[wr_bank] <= 1'b1;

            if (!enable) begin
                wr_cnt <= '0;
            end else if (wr_en) begin
                if (wr_done) begin
                    wr_cnt  <= '0;
                    wr_bank <= ~wr_bank;
                end else begin
                    wr_cnt <= wr_cnt + ADDR_W'(1);
                end
            end

            if (overrun_clr)
                overrun <= 1'b0;
            else if (enable && pcm_valid && full[wr_bank])
                overrun <= 1'b1;
        end
    end

    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        state_nxt    = state;
        rd_en        = 1'b0;
        rd_addr      = rd_ptr;
        release_bank = 1'b0;
        case (state)
            IDLE: begin
                if (full[rd_bank]) begin
                    rd_en     = 1'b1;
                    rd_addr   = '0;
                    state_nxt = FETCH;
                end
            end
            FETCH: begin
                rd_en     = 1'b1;
                state_nxt = STREAM;
            end
            STREAM: begin
                if (xfer) begin
                    if (out_last) begin
                        release_bank = 1'b1;
                        state_nxt    = IDLE;
                    end else begin
                        rd_en = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output register holds beat k while ram_q already holds beat k+1.
    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            rd_bank   <= 1'b0;
            rd_ptr    <= '0;
            beat_idx  <= '0;
            out_pair  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            frame_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (full[rd_bank])
                        rd_ptr <= ADDR_W'(1);
                end
                FETCH: begin
                    rd_ptr    <= rd_ptr + ADDR_W'(1);
                    out_pair  <= ram_q;
                    out_valid <= 1'b1;
                    out_last  <= 1'b0;
                    beat_idx  <= '0;
                end
                STREAM: begin
                    if (xfer) begin
                        if (out_last) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            rd_bank   <= ~rd_bank;
                            frame_cnt <= frame_cnt + CNT_W'(1);
                        end else begin
                            out_pair <= ram_q;
                            rd_ptr   <= rd_ptr + ADDR_W'(1);
                            beat_idx <= beat_idx + ADDR_W'(1);
                            out_last <= (beat_idx == ADDR_W'(FRAME_LEN - 2));
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign m00_axis_tdata  = {{DATA_W{1'b0}}, out_pair[DATA_W-1:0]};
    assign m01_axis_tdata  = {{DATA_W{1'b0}}, out_pair[PAIR_W-1:DATA_W]};
    assign m00_axis_tvalid = out_valid;
    assign m01_axis_tvalid = out_valid;
    assign m00_axis_tlast  = out_last;
    assign m01_axis_tlast  = out_last;
endmodule
